// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions: instruction field positions, widths and the default
// opcode-class masks used by decode and issue logic.
package cpu_isa_pkg;

    localparam int INSTR_W  = 32;
    localparam int OPCODE_W = 5;
    localparam int REG_W    = 5;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 27;
    localparam int RD_HI  = 26;
    localparam int RD_LO  = 22;
    localparam int RS_HI  = 21;
    localparam int RS_LO  = 17;
    localparam int RT_HI  = 16;
    localparam int RT_LO  = 12;

    // Bit n set: opcode n uses rd as its second source operand.
    localparam logic [31:0] DEFAULT_RD_SRC_MASK    = 32'h0000_00D4;
    // Bit n set: opcode n produces a result in rd.
    localparam logic [31:0] DEFAULT_WRITES_RD_MASK = 32'hFFFF_FF29;

    typedef struct packed {
        logic [REG_W-1:0] s1;
        logic [REG_W-1:0] s2;
        logic [REG_W-1:0] d;
        logic             wr;
    } dec_t;

endpackage

// File: rtl/instr_field_decode.sv
// Combinational instruction decoder: extracts source/destination registers and
// whether the instruction writes its destination.
module instr_field_decode
    import cpu_isa_pkg::*;
#(
    parameter logic [31:0] RD_SRC_MASK    = DEFAULT_RD_SRC_MASK,
    parameter logic [31:0] WRITES_RD_MASK = DEFAULT_WRITES_RD_MASK
) (
    input  logic [INSTR_W-1:0] instr,
    output dec_t               dec
);

    logic [OPCODE_W-1:0] opcode;
    logic [REG_W-1:0]    rd;
    logic [REG_W-1:0]    rs;
    logic [REG_W-1:0]    rt;
    logic                unused_low;

    assign opcode     = instr[OPC_HI:OPC_LO];
    assign rd         = instr[RD_HI:RD_LO];
    assign rs         = instr[RS_HI:RS_LO];
    assign rt         = instr[RT_HI:RT_LO];
    assign unused_low = ^instr[RT_LO-1:0];

    always_comb begin
        dec    = '0;
        dec.s1 = rs;
        dec.s2 = RD_SRC_MASK[opcode] ? rd : rt;
        dec.d  = rd;
        // r0 is hardwired zero, so a write to it is never tracked.
        dec.wr = WRITES_RD_MASK[opcode] && (rd != '0);
    end

endmodule

// File: rtl/issue_scoreboard.sv
// Decode-and-issue stage: per-register in-flight write counters gate issue of
// dependent instructions into a single registered valid/ready output slot.
module issue_scoreboard
    import cpu_isa_pkg::*;
#(
    parameter int          NUM_REGS       = 32,
    parameter int          MAX_INFLIGHT   = 3,
    parameter int          WB_PORTS       = 2,
    parameter logic [31:0] RD_SRC_MASK    = DEFAULT_RD_SRC_MASK,
    parameter logic [31:0] WRITES_RD_MASK = DEFAULT_WRITES_RD_MASK
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      in_valid,
    input  logic [INSTR_W-1:0]        in_instr,
    output logic                      in_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [INSTR_W-1:0]        out_instr,
    output logic [REG_W-1:0]          out_s1,
    output logic [REG_W-1:0]          out_s2,
    output logic [REG_W-1:0]          out_d,
    output logic                      out_wr,
    input  logic                      flush,
    input  logic [WB_PORTS-1:0]       wb_valid,
    input  logic [REG_W*WB_PORTS-1:0] wb_reg,
    output logic [NUM_REGS-1:0]       pending,
    output logic                      wb_underflow
);

    localparam int              CNT_W   = $clog2(MAX_INFLIGHT + 1);
    localparam int              IDX_W   = $clog2(NUM_REGS);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INFLIGHT);

    dec_t             dec;
    logic [CNT_W-1:0] cnt_q [NUM_REGS];
    logic [CNT_W-1:0] cnt_d [NUM_REGS];
    logic             hazard;
    logic             accept;
    logic             flush_drop;
    logic             underflow_hit;
    int               delta;
    int               nxt;

    instr_field_decode #(
        .RD_SRC_MASK   (RD_SRC_MASK),
        .WRITES_RD_MASK(WRITES_RD_MASK)
    ) u_decode (
        .instr(in_instr),
        .dec  (dec)
    );

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            pending[r] = (cnt_q[r] != '0);
        end
    end

    // Hazards look only at registered counts: a release unblocks next cycle.
    assign hazard = pending[dec.s1[IDX_W-1:0]] || pending[dec.s2[IDX_W-1:0]] ||
                    (dec.wr && (cnt_q[dec.d[IDX_W-1:0]] == CNT_MAX));

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; valid never waits on ready, and the slot holds stable until
    // out_ready (or flush) retires it. in_ready is independent of in_valid.
    assign in_ready   = !flush && (!out_valid || out_ready) && !hazard;
    assign accept     = in_valid && in_ready;
    assign flush_drop = flush && out_valid && out_wr;

    // All updates to one register are summed, then clamped to 0..MAX_INFLIGHT.
    always_comb begin
        cnt_d         = cnt_q;
        underflow_hit = 1'b0;
        delta         = 0;
        nxt           = 0;
        for (int r = 1; r < NUM_REGS; r++) begin
            delta = 0;
            if (accept && dec.wr && (dec.d == REG_W'(r))) delta = delta + 1;
            if (flush_drop && (out_d == REG_W'(r)))      delta = delta - 1;
            for (int k = 0; k < WB_PORTS; k++) begin
                if (wb_valid[k] && (wb_reg[REG_W*k +: REG_W] == REG_W'(r))) begin
                    if (cnt_q[r] == '0) underflow_hit = 1'b1;
                    else                delta = delta - 1;
                end
            end
            nxt = int'(cnt_q[r]) + delta;
            if (nxt < 0)                 nxt = 0;
            else if (nxt > MAX_INFLIGHT) nxt = MAX_INFLIGHT;
            cnt_d[r] = CNT_W'(nxt);
        end
        cnt_d[0] = '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
            wb_underflow <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
            if (underflow_hit) wb_underflow <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_s1    <= '0;
            out_s2    <= '0;
            out_d     <= '0;
            out_wr    <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_instr <= in_instr;
            out_s1    <= dec.s1;
            out_s2    <= dec.s2;
            out_d     <= dec.d;
            out_wr    <= dec.wr;
        end else if (out_valid && (flush || out_ready)) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/issue_scoreboard.md
# issue_scoreboard

Decode-and-issue stage for the pipelined processor. Extracts the source and destination register fields from each instruction and tracks in-flight writes in a per-register scoreboard. Holds back any instruction whose sources are still pending, then hands accepted instructions to the execute stage through one registered valid/ready slot. Sits between fetch and the register file / execute pipeline and replaces ad-hoc stall logic.

## Interface
Parameters:
- NUM_REGS, 32: architectural registers; must be a power of two, at most 32. Register 0 is hardwired zero and never tracked.
- MAX_INFLIGHT, 3: maximum outstanding writes per register.
- WB_PORTS, 2: number of writeback (release) ports.
- RD_SRC_MASK, 32'h0000_00D4: bit n set means opcode n reads rd as its second source (opcodes 2, 4, 6, 7).
- WRITES_RD_MASK, 32'hFFFF_FF29: bit n set means opcode n writes rd.

Ports:
- clock  in  1  sole clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  fetch presents an instruction.
- in_instr  in  32  instruction: opcode [31:27], rd [26:22], rs [21:17], rt [16:12].
- in_ready  out  1  instruction accepted this cycle when in_valid is also high.
- out_valid  out  1  registered issue slot holds an instruction.
- out_ready  in  1  execute stage consumes the slot.
- out_instr  out  32  held instruction.
- out_s1, out_s2, out_d  out  5 each  decoded source 1, source 2 and destination.
- out_wr  out  1  held instruction writes out_d; forced 0 when out_d is 0.
- flush  in  1  discard the held instruction.
- wb_valid  in  WB_PORTS  per-port write completion.
- wb_reg  in  5*WB_PORTS  register released by each port; port k uses bits [5k+4:5k].
- pending  out  NUM_REGS  bit r set when count[r] is nonzero.
- wb_underflow  out  1  sticky error; set when a release hits a register whose count is 0.

## Operation
- Decode, combinational on in_instr:
  - s1 is rs.
  - s2 is rd if RD_SRC_MASK[opcode] is set, otherwise rt.
  - d is rd.
  - wr is WRITES_RD_MASK[opcode] AND (d != 0).
- Scoreboard: one counter count[r] per register, width clog2(MAX_INFLIGHT+1). count[0] stays 0.
- Hazards:
  - hazard is true when count[s1] != 0, or count[s2] != 0, or (wr AND count[d] == MAX_INFLIGHT).
  - Hazards are evaluated against registered counts only. A release in cycle N unblocks in cycle N+1; there is no same-cycle bypass.
- in_ready is high when all of these hold:
  - flush is low;
  - the slot is free, i.e. out_valid is 0 or out_ready is 1;
  - hazard is false.
  - in_ready depends combinationally on in_instr; fetch must hold in_instr stable while in_valid is high.
- Accept (in_valid AND in_ready):
  - The slot loads instr, s1, s2, d and wr.
  - out_valid becomes 1.
  - If wr is set, count[d] increments.
- Consume (out_valid AND out_ready with no new accept): out_valid becomes 0.
- Flush (flush AND out_valid):
  - out_valid becomes 0.
  - If the held out_wr is set, count[out_d] decrements, since that write will never complete.
  - flush has priority over out_ready in the same cycle.
- Release: each port with wb_valid set decrements count[wb_reg].
  - A release to register 0 is ignored.
  - A release to a register whose count is 0 leaves the count unchanged and sets wb_underflow.
- Simultaneous updates to the same register (accept increment, flush decrement, several release ports) are summed into one net update per cycle. The result is clamped to the range 0..MAX_INFLIGHT.

## Timing
- Reset values: out_valid 0; out_instr, out_s1, out_s2 and out_d 0; out_wr 0; every count 0, so pending is 0; wb_underflow 0; in_ready follows its equation.
- Reset asserted mid-operation clears the slot and all counts immediately; in-flight writebacks after reset are treated as underflows.
- Issue latency: one cycle from accept to out_valid.
- Throughput: one instruction per cycle when out_ready is held high and there are no hazards.
- Dependent back-to-back pair: the consumer stalls until the cycle after the producer's release.
- out_* hold stable while out_valid is 1 and out_ready is 0.

## Structure
- Shared package `cpu_isa_pkg` holds:
  - field positions (OPC_HI/LO, RD_HI/LO, RS_HI/LO, RT_HI/LO);
  - OPCODE_W = 5 and REG_W = 5;
  - the default mask constants.
- One sub-module, `instr_field_decode`, a purely combinational instruction-to-{s1, s2, d, wr} decoder parametrised by the two masks.
- The scoreboard counters and the issue slot live in the top module.

## Test plan
- Reset, then issue 0x00C22000 (add r3,r1,r2) with out_ready=1: out_valid next cycle; out_s1=1, out_s2=2, out_d=3, out_wr=1; pending[3]=1.
- Issue 0x01065000 (reads r3) right after that: in_ready=0 until the cycle after wb_valid[0]=1, wb_reg=3; then it issues and pending[4]=1.
- Issue 0x38C20000 (opcode 7, rd is a source): out_s2=3, out_wr=0; a pending write to r3 blocks it.
- Issue four writes to r5 with no releases and MAX_INFLIGHT=3: the 4th stalls. Then assert two releases to r5 in one cycle: count[5] drops to 1 and the 4th issues next cycle.
- Hold out_ready=0 with a writer of r6 in the slot, then pulse flush: out_valid=0 and pending[6]=0 the next cycle; in_ready=0 during the flush cycle.
- Release to r9 with count 0: wb_underflow=1 and stays set until reset_n is asserted; a release to r0 leaves wb_underflow=0.
